// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, arbiter state encoding and small helpers.
package uart_pkg;

    localparam int DATA_W = 8;

    // Arbiter state encoding, kept numeric so other UART blocks can decode it.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_START = START,
        ST_WAIT  = WAIT,
        ST_NEXT  = NEXT
    } arb_state_e;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the shared transmitter handshake.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]                  req_valid;
    logic [uart_pkg::DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]                  req_last;
    logic [NUM_REQ-1:0]                  req_ready;
    logic                                tx_start;
    logic [uart_pkg::DATA_W-1:0]         tx_data;
    logic                                tx_busy;
    logic                                tx_clear_req;

    // Environment side: requesters and the transmitter.
    modport master (
        output req_valid, req_data, req_last, tx_busy, tx_clear_req,
        input  req_ready, tx_start, tx_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_data, req_last, tx_busy, tx_clear_req,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit at or above i_ptr, wrapping.
module uart_tx_arbiter_rr_pick
    import uart_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    // Rotate the request vector so the pointer position lands at bit 0.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N'(w_dbl >> i_ptr);

    // Lowest set bit of the rotated vector is the distance from the pointer.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding a value (no latch).
    always_comb begin
        w_off   = '0;
        o_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off   = IW'(k);
                o_found = 1'b1;
            end
        end
    end

    // Undo the rotation: pointer + distance, modulo N.
    assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx = (w_sum >= (IW + 1)'(N)) ? IW'(w_sum - (IW + 1)'(N)) : w_sum[IW-1:0];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one UART transmitter between NUM_REQ byte streams.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int MAX_BURST = 16,
    localparam int IDX_W     = idx_width(NUM_REQ)
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    uart_tx_arbiter_if.slave   bus,
    output logic [IDX_W-1:0]   grant_id,
    output logic               arb_busy
);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_grant_id;
    logic [DATA_W-1:0]   r_tx_data;
    logic [7:0]          r_burst_cnt;
    logic                r_last_flag;

    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_found;
    logic                w_owner_valid;
    logic                w_owner_last;
    logic [DATA_W-1:0]   w_owner_data;
    logic                w_transfer;
    logic                w_keep_lock;
    logic [IDX_W-1:0]    w_ptr_next;
    logic [NUM_REQ-1:0]  w_req_ready;

    uart_tx_arbiter_rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .i_req   (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    // Owner's byte stream and the lock decision.
    assign w_owner_valid = bus.req_valid[r_grant_id];
    assign w_owner_last  = bus.req_last[r_grant_id];
    assign w_owner_data  = DATA_W'(bus.req_data >> (DATA_W * int'(r_grant_id)));
    assign w_transfer    = (r_state == ST_ISSUE) && w_owner_valid && !bus.tx_busy;
    assign w_keep_lock   = !r_last_flag && (r_burst_cnt < 8'(MAX_BURST)) && w_owner_valid;
    assign w_ptr_next    = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Next-state logic; tx_clear_req only matters while waiting on a started byte.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (w_pick_found) w_next_state = ST_ISSUE;
            ST_ISSUE: begin
                if (w_transfer)          w_next_state = ST_START;
                else if (!w_owner_valid) w_next_state = ST_NEXT;
            end
            ST_START: w_next_state = ST_WAIT;
            ST_WAIT:  if (bus.tx_clear_req) w_next_state = ST_NEXT;
            ST_NEXT:  w_next_state = w_keep_lock ? ST_ISSUE : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // One-hot accept pulse, only to the owner and only while the transmitter is free.
    always_comb begin
        w_req_ready = '0;
        if (w_transfer) w_req_ready[r_grant_id] = 1'b1;
    end

    // Grant, burst counter, byte/last latch and round-robin pointer.
    // NOTE: tx_data is a data register but still reset, because its value is visible on the port.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_tx_data   <= '0;
            r_burst_cnt <= '0;
            r_last_flag <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_pick_found) begin
                r_grant_id  <= w_pick_idx;
                r_burst_cnt <= '0;
            end
            if (w_transfer) begin
                r_tx_data   <= w_owner_data;
                r_last_flag <= w_owner_last;
                r_burst_cnt <= r_burst_cnt + 8'd1;
            end else if (r_state == ST_ISSUE && !w_owner_valid) begin
                // Owner withdrew before handing over a byte: release the lock.
                r_last_flag <= 1'b1;
            end
            if (r_state == ST_NEXT && !w_keep_lock) r_rr_ptr <= w_ptr_next;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.tx_start  = (r_state == ST_START);
    assign bus.tx_data   = r_tx_data;
    assign grant_id      = r_grant_id;
    assign arb_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed timing steps plus randomized
// message streams compared against a message-level round-robin model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ   = 2;
    localparam int MAX_BURST = 4;
    localparam int IDX_W     = idx_width(NUM_REQ);

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } item_t;

    typedef struct packed {
        logic [IDX_W-1:0] owner;
        logic [7:0]       data;
    } tx_rec_t;

    logic             wb_clk_i = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic [IDX_W-1:0] grant_id;
    logic             arb_busy;

    int      n_checks = 0;
    int      n_errors = 0;
    int      n_viol   = 0;
    int      exp_ptr  = 0;
    item_t   rq[NUM_REQ][$];
    tx_rec_t obs_q[$];
    tx_rec_t exp_q[$];

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus),
        .grant_id (grant_id),
        .arb_busy (arb_busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic l);
        bus.req_valid[i]      = 1'b1;
        bus.req_data[8*i +: 8] = d;
        bus.req_last[i]       = l;
    endtask

    task automatic clr_req(input int i);
        bus.req_valid[i]      = 1'b0;
        bus.req_data[8*i +: 8] = 8'h00;
        bus.req_last[i]       = 1'b0;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NUM_REQ; i++) clr_req(i);
        bus.tx_busy      = 1'b0;
        bus.tx_clear_req = 1'b0;
    endtask

    // Assert reset with whatever inputs are present, check outputs at once, then release.
    task automatic do_reset(input string tag);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        #1;
        check({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        check({tag, "_ready"},    32'(bus.req_ready), 32'd0);
        check({tag, "_tx_data"},  32'(bus.tx_data), 32'h00);
        check({tag, "_grant"},    32'(grant_id), 32'd0);
        check({tag, "_busy"},     32'(arb_busy), 32'd0);
        idle_inputs();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        exp_ptr  = 0;
    endtask

    // Message-level model: owner chosen round-robin from the pointer, keeps the
    // transmitter until a last byte, MAX_BURST bytes, or its stream runs dry.
    task automatic predict();
        item_t   mq[NUM_REQ][$];
        item_t   it;
        tx_rec_t rec;
        int      ptr;
        int      k;
        int      cnt;
        for (int i = 0; i < NUM_REQ; i++) mq[i] = rq[i];
        ptr = exp_ptr;
        exp_q.delete();
        while (1) begin
            k = -1;
            for (int o = 0; o < NUM_REQ; o++)
                if (k < 0 && mq[(ptr + o) % NUM_REQ].size() > 0) k = (ptr + o) % NUM_REQ;
            if (k < 0) break;
            cnt = 0;
            do begin
                it        = mq[k].pop_front();
                rec.owner = IDX_W'(k);
                rec.data  = it.data;
                exp_q.push_back(rec);
                cnt++;
            end while (!it.last && cnt < MAX_BURST && mq[k].size() > 0);
            ptr = (k + 1) % NUM_REQ;
        end
        exp_ptr = ptr;
    endtask

    // Drive preloaded requester queues and a transmitter with random byte times.
    task automatic run_auto(input string tag);
        bit         pending = 1'b0;
        bit         done    = 1'b0;
        bit         empty;
        int         cnt     = 0;
        int         cyc     = 0;
        logic [7:0] cap     = 8'h00;
        tx_rec_t    rec;
        predict();
        obs_q.delete();
        while (!done && cyc < 2000) begin
            @(negedge wb_clk_i);
            cyc++;
            if (bus.tx_start === 1'b1) begin
                if (pending) n_viol++;
                rec.owner = grant_id;
                rec.data  = bus.tx_data;
                obs_q.push_back(rec);
                cap     = bus.tx_data;
                pending = 1'b1;
                cnt     = $urandom_range(1, 4);
            end else if (pending && bus.tx_data !== cap) begin
                n_viol++;
            end
            bus.tx_clear_req = 1'b0;
            if (pending) begin
                if (cnt == 0) begin
                    bus.tx_clear_req = 1'b1;
                    bus.tx_busy      = 1'b0;
                    pending          = 1'b0;
                end else begin
                    cnt--;
                    bus.tx_busy = 1'b1;
                end
            end else begin
                bus.tx_busy = ($urandom_range(0, 3) == 0);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (rq[i].size() > 0) set_req(i, rq[i][0].data, rq[i][0].last);
                else                  clr_req(i);
            end
            #1;
            if ($countones(bus.req_ready) > 1) n_viol++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.req_ready[i] === 1'b1) begin
                    if (i != int'(grant_id) || !bus.req_valid[i]) n_viol++;
                    else void'(rq[i].pop_front());
                end
            end
            empty = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() > 0) empty = 1'b0;
            done = empty && !pending && !bus.tx_clear_req && (arb_busy === 1'b0);
        end
        check({tag, "_finished"}, 32'(done), 32'd1);
        idle_inputs();
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                check($sformatf("%s[%0d].owner", tag, i), 32'(obs_q[i].owner), 32'(exp_q[i].owner));
                check($sformatf("%s[%0d].data", tag, i),  32'(obs_q[i].data),  32'(exp_q[i].data));
            end
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic l);
        item_t it;
        it.data = d;
        it.last = l;
        rq[i].push_back(it);
    endtask

    task automatic load_random();
        int nm;
        int len;
        for (int i = 0; i < NUM_REQ; i++) begin
            nm = $urandom_range(1, 3);
            for (int m = 0; m < nm; m++) begin
                len = $urandom_range(1, 6);
                for (int b = 0; b < len; b++)
                    push(i, 8'($urandom), (b == len - 1) && ($urandom_range(0, 3) != 0));
            end
        end
    endtask

    initial begin
        int hold_bad;
        idle_inputs();
        do_reset("rst0");

        // Single byte from req0: ready in ISSUE, start one cycle later, idle after clear.
        @(negedge wb_clk_i); set_req(0, 8'h41, 1'b1);
        @(negedge wb_clk_i);
        check("t1_ready", 32'(bus.req_ready), 32'b01);
        check("t1_no_start_yet", 32'(bus.tx_start), 32'd0);
        @(negedge wb_clk_i);
        check("t1_start", 32'(bus.tx_start), 32'd1);
        check("t1_data", 32'(bus.tx_data), 32'h41);
        check("t1_ready_off", 32'(bus.req_ready), 32'd0);
        clr_req(0);
        @(negedge wb_clk_i);
        check("t1_start_one_cycle", 32'(bus.tx_start), 32'd0);
        check("t1_data_hold", 32'(bus.tx_data), 32'h41);
        bus.tx_clear_req = 1'b1;
        @(negedge wb_clk_i); bus.tx_clear_req = 1'b0;
        @(negedge wb_clk_i);
        check("t1_idle", 32'(arb_busy), 32'd0);
        exp_ptr = 1;
        // Pointer now at 1: with both waiting, req1 goes first.
        push(0, 8'h50, 1'b1);
        push(1, 8'h60, 1'b1);
        run_auto("t1_rr");

        // Three-byte message from req0 locks out req1; req0 regains afterwards.
        do_reset("rst2");
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1); push(0, 8'h13, 1'b1);
        push(1, 8'h20, 1'b1);
        run_auto("t2_lock");

        // Burst limit forces rotation without a last flag.
        do_reset("rst3");
        for (int b = 0; b < 6; b++) push(0, 8'hA0 + 8'(b), 1'b0);
        push(1, 8'hB0, 1'b1);
        run_auto("t3_burst");

        // Transmitter busy held in ISSUE, with a stray clear pulse ignored.
        @(negedge wb_clk_i); bus.tx_busy = 1'b1; set_req(0, 8'h55, 1'b1);
        hold_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge wb_clk_i);
            bus.tx_clear_req = (c == 4);
            #1;
            if (bus.req_ready !== '0 || bus.tx_start !== 1'b0 || arb_busy !== 1'b1) hold_bad++;
        end
        check("t4_hold", 32'(hold_bad), 32'd0);
        @(negedge wb_clk_i); bus.tx_busy = 1'b0; bus.tx_clear_req = 1'b0; #1;
        check("t4_ready_after_busy", 32'(bus.req_ready), 32'b01);
        @(negedge wb_clk_i);
        check("t4_start", 32'(bus.tx_start), 32'd1);
        check("t4_data", 32'(bus.tx_data), 32'h55);
        clr_req(0);
        @(negedge wb_clk_i); bus.tx_clear_req = 1'b1;
        @(negedge wb_clk_i); bus.tx_clear_req = 1'b0;
        @(negedge wb_clk_i);
        check("t4_idle", 32'(arb_busy), 32'd0);

        // Owner stops mid-message; req1 gets the transmitter next.
        do_reset("rst5");
        push(0, 8'h30, 1'b0);
        push(1, 8'h40, 1'b1);
        run_auto("t5_drop");
        // Requester withdraws before handing over a byte, then a stray clear in IDLE.
        @(negedge wb_clk_i); set_req(0, 8'h31, 1'b0);
        @(negedge wb_clk_i); clr_req(0); #1;
        check("t5_withdraw_ready", 32'(bus.req_ready), 32'd0);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check("t5_withdraw_idle", 32'(arb_busy), 32'd0);
        bus.tx_clear_req = 1'b1;
        @(negedge wb_clk_i); bus.tx_clear_req = 1'b0;
        check("t5_spurious_clear_busy", 32'(arb_busy), 32'd0);
        check("t5_spurious_clear_start", 32'(bus.tx_start), 32'd0);
        exp_ptr = 1;
        push(0, 8'h32, 1'b1);
        push(1, 8'h41, 1'b1);
        run_auto("t5_after");

        // Reset while a byte from req1 is in flight.
        @(negedge wb_clk_i); set_req(1, 8'h77, 1'b1);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        check("t6_start", 32'(bus.tx_start), 32'd1);
        clr_req(1);
        set_req(1, 8'h78, 1'b1);
        @(negedge wb_clk_i);
        check("t6_in_wait", 32'(arb_busy), 32'd1);
        check("t6_wait_data", 32'(bus.tx_data), 32'h77);
        do_reset("t6_rst");
        push(1, 8'h88, 1'b1);
        run_auto("t6_after");

        // Randomized message streams.
        for (int r = 0; r < 4; r++) begin
            load_random();
            run_auto($sformatf("rnd%0d", r));
        end

        check("protocol_violations", 32'(n_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
